// File: rtl/regfile_read_ctrl.sv
// 16 x 32-bit register file with two independent registered read ports (valid/ready, 1-cycle).
// Define REGFILE_BYPASS_EN to forward same-cycle write data into a granted read.
module regfile_read_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic              rd_gnt_a,
    output logic              rd_valid_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic              rd_ready_a,
    input  logic              rd_req_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_gnt_b,
    output logic              rd_valid_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              rd_ready_b
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        StEmpty,
        StFull
    } rd_state_e;

    logic [DATA_W-1:0]  regs_q [NumRegs];
    logic [NumRegs-1:0] reg_load;

    always_comb begin
        reg_load = '0;
        if (ld) begin
            reg_load[wr_addr] = 1'b1;
        end
    end

    for (genvar g = 0; g < NumRegs; g++) begin : g_regs
        always_ff @(posedge clk) begin
            if (rst) begin
                regs_q[g] <= '0;
            end else if (reg_load[g]) begin
                regs_q[g] <= wr_data;
            end
        end
    end

    // Word each port would capture if granted this cycle.
    logic [DATA_W-1:0] rd_word_a;
    logic [DATA_W-1:0] rd_word_b;

    always_comb begin
        rd_word_a = regs_q[rd_addr_a];
        rd_word_b = regs_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (ld && (wr_addr == rd_addr_a)) begin
            rd_word_a = wr_data;
        end
        if (ld && (wr_addr == rd_addr_b)) begin
            rd_word_b = wr_data;
        end
`endif
    end

    // Port A
    rd_state_e         state_a_q, state_a_d;
    logic [DATA_W-1:0] data_a_q, data_a_d;

    always_comb begin
        state_a_d = state_a_q;
        data_a_d  = data_a_q;
        rd_gnt_a  = 1'b0;
        unique case (state_a_q)
            StEmpty: begin
                rd_gnt_a = rd_req_a;
                if (rd_req_a) begin
                    data_a_d  = rd_word_a;
                    state_a_d = StFull;
                end
            end
            StFull: begin
                rd_gnt_a = rd_req_a & rd_ready_a;
                if (rd_ready_a) begin
                    if (rd_req_a) begin
                        data_a_d = rd_word_a;
                    end else begin
                        state_a_d = StEmpty;
                    end
                end
            end
        endcase
        // Requests during reset are dropped, so never advertise a grant.
        if (rst) begin
            rd_gnt_a = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_a_q <= StEmpty;
            data_a_q  <= '0;
        end else begin
            state_a_q <= state_a_d;
            data_a_q  <= data_a_d;
        end
    end

    assign rd_valid_a = (state_a_q == StFull);
    assign rd_data_a  = data_a_q;

    // Port B
    rd_state_e         state_b_q, state_b_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;

    always_comb begin
        state_b_d = state_b_q;
        data_b_d  = data_b_q;
        rd_gnt_b  = 1'b0;
        unique case (state_b_q)
            StEmpty: begin
                rd_gnt_b = rd_req_b;
                if (rd_req_b) begin
                    data_b_d  = rd_word_b;
                    state_b_d = StFull;
                end
            end
            StFull: begin
                rd_gnt_b = rd_req_b & rd_ready_b;
                if (rd_ready_b) begin
                    if (rd_req_b) begin
                        data_b_d = rd_word_b;
                    end else begin
                        state_b_d = StEmpty;
                    end
                end
            end
        endcase
        if (rst) begin
            rd_gnt_b = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_b_q <= StEmpty;
            data_b_q  <= '0;
        end else begin
            state_b_q <= state_b_d;
            data_b_q  <= data_b_d;
        end
    end

    assign rd_valid_b = (state_b_q == StFull);
    assign rd_data_b  = data_b_q;

endmodule

// File: tb/tb_regfile_read_ctrl.sv
// Self-checking bench for regfile_read_ctrl: directed scenarios plus randomized traffic
// checked against an array-based reference model of the register file and read ports.
module tb_regfile_read_ctrl;

    logic        clk = 1'b0;
    logic        rst, ld;
    logic [3:0]  wr_addr, rd_addr_a, rd_addr_b;
    logic [31:0] wr_data, rd_data_a, rd_data_b;
    logic        rd_req_a, rd_req_b, rd_ready_a, rd_ready_b;
    logic        rd_gnt_a, rd_gnt_b, rd_valid_a, rd_valid_b;

    always #5 clk = ~clk;

    regfile_read_ctrl #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld         (ld),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_req_a   (rd_req_a),
        .rd_addr_a  (rd_addr_a),
        .rd_gnt_a   (rd_gnt_a),
        .rd_valid_a (rd_valid_a),
        .rd_data_a  (rd_data_a),
        .rd_ready_a (rd_ready_a),
        .rd_req_b   (rd_req_b),
        .rd_addr_b  (rd_addr_b),
        .rd_gnt_b   (rd_gnt_b),
        .rd_valid_b (rd_valid_b),
        .rd_data_b  (rd_data_b),
        .rd_ready_b (rd_ready_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_regs [16];
    logic        m_valid_a = 1'b0, m_valid_b = 1'b0;
    logic [31:0] m_data_a = '0, m_data_b = '0;
    logic        e_gnt_a, e_gnt_b, o_gnt_a, o_gnt_b;

    function automatic logic [31:0] fetch(input logic [3:0] a);
`ifdef REGFILE_BYPASS_EN
        if (ld && wr_addr == a) return wr_data;
`endif
        return m_regs[a];
    endfunction

    // Advance one clock: sample grants mid-cycle, update the model at the edge.
    task automatic cycle();
        @(negedge clk);
        o_gnt_a = rd_gnt_a;
        o_gnt_b = rd_gnt_b;
        e_gnt_a = !rst && rd_req_a && (!m_valid_a || rd_ready_a);
        e_gnt_b = !rst && rd_req_b && (!m_valid_b || rd_ready_b);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            m_valid_a = 1'b0; m_data_a = '0;
            m_valid_b = 1'b0; m_data_b = '0;
        end else begin
            if (e_gnt_a) begin
                m_data_a = fetch(rd_addr_a); m_valid_a = 1'b1;
            end else if (rd_ready_a) begin
                m_valid_a = 1'b0;
            end
            if (e_gnt_b) begin
                m_data_b = fetch(rd_addr_b); m_valid_b = 1'b1;
            end else if (rd_ready_b) begin
                m_valid_b = 1'b0;
            end
            if (ld) m_regs[wr_addr] = wr_data;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; ld = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req_a = 1'b0; rd_addr_a = '0; rd_ready_a = 1'b0;
        rd_req_b = 1'b0; rd_addr_b = '0; rd_ready_b = 1'b0;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        ld = 1'b1; wr_addr = a; wr_data = d;
        cycle();
        ld = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        n_checks++; if (rd_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a: got %b want 0", rd_valid_a); end
        n_checks++; if (rd_data_a !== 32'h0) begin n_fail++; $display("FAIL reset_data_a: got %h want 0", rd_data_a); end
        n_checks++; if (rd_valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b: got %b want 0", rd_valid_b); end
        n_checks++; if (rd_data_b !== 32'h0) begin n_fail++; $display("FAIL reset_data_b: got %h want 0", rd_data_b); end
        rd_req_a = 1'b1; rd_addr_a = 4'd5;
        cycle();
        n_checks++; if (o_gnt_a !== 1'b1) begin n_fail++; $display("FAIL reset_read_gnt_a: got %b want 1", o_gnt_a); end
        n_checks++; if (rd_valid_a !== 1'b1) begin n_fail++; $display("FAIL reset_read_valid_a: got %b want 1", rd_valid_a); end
        n_checks++; if (rd_data_a !== 32'h0) begin n_fail++; $display("FAIL reset_read_data_a: got %h want 0", rd_data_a); end
        rd_req_a = 1'b0; rd_ready_a = 1'b1;
        cycle();
        n_checks++; if (rd_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_drain_a: got %b want 0", rd_valid_a); end
    endtask

    task automatic test_write_readback();
        write_reg(4'd3, 32'hFFFF_FF00);
        rd_req_b = 1'b1; rd_addr_b = 4'd3; rd_ready_b = 1'b1;
        cycle();
        n_checks++; if (o_gnt_b !== 1'b1) begin n_fail++; $display("FAIL wr_rd_gnt_b: got %b want 1", o_gnt_b); end
        n_checks++; if (rd_valid_b !== 1'b1) begin n_fail++; $display("FAIL wr_rd_valid_b: got %b want 1", rd_valid_b); end
        n_checks++; if (rd_data_b !== 32'hFFFF_FF00) begin n_fail++; $display("FAIL wr_rd_data_b: got %h want ffffff00", rd_data_b); end
        rd_req_b = 1'b0;
        cycle();
        n_checks++; if (rd_valid_b !== 1'b0) begin n_fail++; $display("FAIL wr_rd_drain_b: got %b want 0", rd_valid_b); end
        rd_ready_b = 1'b0;
    endtask

    task automatic test_backpressure();
        write_reg(4'd9, 32'hAABB_AABB);
        write_reg(4'd10, 32'h1234_5678);
        rd_req_a = 1'b1; rd_addr_a = 4'd9; rd_ready_a = 1'b0;
        cycle();
        n_checks++; if (rd_data_a !== 32'hAABB_AABB) begin n_fail++; $display("FAIL bp_load_a: got %h want aabbaabb", rd_data_a); end
        rd_addr_a = 4'd10;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++; if (o_gnt_a !== 1'b0) begin n_fail++; $display("FAIL bp_gnt_a[%0d]: got %b want 0", i, o_gnt_a); end
            n_checks++; if (rd_valid_a !== 1'b1) begin n_fail++; $display("FAIL bp_valid_a[%0d]: got %b want 1", i, rd_valid_a); end
            n_checks++; if (rd_data_a !== 32'hAABB_AABB) begin n_fail++; $display("FAIL bp_hold_a[%0d]: got %h want aabbaabb", i, rd_data_a); end
        end
        rd_ready_a = 1'b1;
        cycle();
        n_checks++; if (o_gnt_a !== 1'b1) begin n_fail++; $display("FAIL bp_release_gnt_a: got %b want 1", o_gnt_a); end
        n_checks++; if (rd_data_a !== 32'h1234_5678) begin n_fail++; $display("FAIL bp_release_data_a: got %h want 12345678", rd_data_a); end
        rd_req_a = 1'b0;
        cycle();
        n_checks++; if (rd_valid_a !== 1'b0) begin n_fail++; $display("FAIL bp_drain_a: got %b want 0", rd_valid_a); end
    endtask

    task automatic test_collision();
        logic [31:0] want;
`ifdef REGFILE_BYPASS_EN
        want = 32'h2222_2222;
`else
        want = 32'h1111_1111;
`endif
        write_reg(4'd7, 32'h1111_1111);
        ld = 1'b1; wr_addr = 4'd7; wr_data = 32'h2222_2222;
        rd_req_a = 1'b1; rd_addr_a = 4'd7; rd_ready_a = 1'b1;
        rd_req_b = 1'b1; rd_addr_b = 4'd7; rd_ready_b = 1'b1;
        cycle();
        ld = 1'b0;
        n_checks++; if (rd_data_a !== want) begin n_fail++; $display("FAIL collide_a: got %h want %h", rd_data_a, want); end
        n_checks++; if (rd_data_b !== want) begin n_fail++; $display("FAIL collide_same_b: got %h want %h", rd_data_b, want); end
        cycle();
        n_checks++; if (rd_data_a !== 32'h2222_2222) begin n_fail++; $display("FAIL collide_next_a: got %h want 22222222", rd_data_a); end
        rd_req_a = 1'b0; rd_req_b = 1'b0;
        cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) write_reg(4'(i), 32'hC0DE_0000 + 32'(i) * 32'h1111);
        rd_ready_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd_req_a = 1'b1; rd_addr_a = 4'(i);
            cycle();
            n_checks++; if (rd_valid_a !== 1'b1) begin n_fail++; $display("FAIL stream_valid_a[%0d]: got %b want 1", i, rd_valid_a); end
            n_checks++; if (rd_data_a !== 32'hC0DE_0000 + 32'(i) * 32'h1111) begin
                n_fail++; $display("FAIL stream_data_a[%0d]: got %h want %h", i, rd_data_a, 32'hC0DE_0000 + 32'(i) * 32'h1111);
            end
        end
        rd_req_a = 1'b0;
        cycle();
        n_checks++; if (rd_valid_a !== 1'b0) begin n_fail++; $display("FAIL stream_drop_a: got %b want 0", rd_valid_a); end
        n_checks++; if (rd_data_a !== 32'hC0DE_4444) begin n_fail++; $display("FAIL stream_keep_a: got %h want c0de4444", rd_data_a); end
    endtask

    task automatic test_mid_reset();
        write_reg(4'd12, 32'h0000_FFFF);
        rd_req_b = 1'b1; rd_addr_b = 4'd12; rd_ready_b = 1'b0;
        cycle();
        rd_req_b = 1'b0;
        cycle();
        n_checks++; if (rd_data_b !== 32'h0000_FFFF) begin n_fail++; $display("FAIL midrst_pre_b: got %h want 0000ffff", rd_data_b); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_checks++; if (rd_valid_b !== 1'b0) begin n_fail++; $display("FAIL midrst_valid_b: got %b want 0", rd_valid_b); end
        n_checks++; if (rd_data_b !== 32'h0) begin n_fail++; $display("FAIL midrst_data_b: got %h want 0", rd_data_b); end
        rd_ready_a = 1'b1; rd_ready_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_req_a = 1'b1; rd_addr_a = 4'(i);
            rd_req_b = 1'b1; rd_addr_b = 4'(15 - i);
            cycle();
            n_checks++; if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
                n_fail++; $display("FAIL midrst_regs[%0d]: got a=%h b=%h want 0", i, rd_data_a, rd_data_b);
            end
        end
        rd_req_a = 1'b0; rd_req_b = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(63) == 0);
            ld         = $urandom_range(1);
            wr_addr    = 4'($urandom_range(15));
            wr_data    = $urandom;
            rd_req_a   = ($urandom_range(3) != 0);
            rd_addr_a  = 4'($urandom_range(15));
            rd_ready_a = $urandom_range(1);
            rd_req_b   = ($urandom_range(3) != 0);
            rd_addr_b  = 4'($urandom_range(15));
            rd_ready_b = $urandom_range(1);
            cycle();
            n_checks++; if (o_gnt_a !== e_gnt_a || o_gnt_b !== e_gnt_b) begin
                n_fail++; $display("FAIL rand_gnt[%0d]: got a=%b b=%b want a=%b b=%b", n, o_gnt_a, o_gnt_b, e_gnt_a, e_gnt_b);
            end
            n_checks++; if (rd_valid_a !== m_valid_a || rd_data_a !== m_data_a) begin
                n_fail++; $display("FAIL rand_port_a[%0d]: got v=%b d=%h want v=%b d=%h", n, rd_valid_a, rd_data_a, m_valid_a, m_data_a);
            end
            n_checks++; if (rd_valid_b !== m_valid_b || rd_data_b !== m_data_b) begin
                n_fail++; $display("FAIL rand_port_b[%0d]: got v=%b d=%h want v=%b d=%h", n, rd_valid_b, rd_data_b, m_valid_b, m_data_b);
            end
        end
        idle_inputs();
        cycle();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_readback();
        test_backpressure();
        test_collision();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
